// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - period / high-time meter and steady-tone detector
//
// Purpose: samples an asynchronous square wave on clk and measures the
// rising-to-rising period and the high time in clk cycles. It flags a steady
// tone once enough consecutive periods agree within a tolerance.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   toneIn      asynchronous square-wave input
//   period      last measured period in clk cycles (0 when no tone)
//   highTime    clk cycles the input was high during that period
//   periodValid one-cycle pulse when period/highTime update
//   toneActive  steady tone present
module tone_period_meter #(
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = 1000000,
  parameter int STABLE_N = 4,
  parameter int TOL      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                toneIn,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] highTime,
  output logic                periodValid,
  output logic                toneActive
);

  localparam int SC_W = $clog2(STABLE_N + 1);
  localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(TIMEOUT - 1);
  localparam logic [PERIOD_W:0]   TOL_EXT  = (PERIOD_W + 1)'(TOL);
  localparam logic [SC_W-1:0]     SC_MAX   = SC_W'(STABLE_N);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t              state;
  logic                s1, s2, s3;
  logic                rise;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] hcnt;
  logic [SC_W-1:0]     stableCnt;

  logic [PERIOD_W-1:0] newPeriod;
  logic [PERIOD_W:0]   newExt;
  logic [PERIOD_W:0]   prevExt;
  logic [PERIOD_W:0]   diff;
  logic [SC_W-1:0]     nextStable;

  // Every edge passes through the same three flops, so the fixed latency
  // cancels out of both the period and the high-time measurement.
  assign rise = s2 & ~s3;

  // The period register still holds the previous measurement while in
  // MEASURE, so it doubles as the reference for the stability comparison.
  // stableCnt==0 marks the first period after IDLE or reset.
  always_comb begin
    newPeriod  = cnt + 1'b1;
    newExt     = {1'b0, newPeriod};
    prevExt    = {1'b0, period};
    diff       = (newExt >= prevExt) ? (newExt - prevExt) : (prevExt - newExt);
    nextStable = stableCnt;
    if (stableCnt == '0) begin
      nextStable = SC_W'(1);
    end else if (diff <= TOL_EXT) begin
      nextStable = (stableCnt == SC_MAX) ? SC_MAX : stableCnt + 1'b1;
    end else begin
      nextStable = SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      hcnt        <= '0;
      stableCnt   <= '0;
      period      <= '0;
      highTime    <= '0;
      periodValid <= 1'b0;
      toneActive  <= 1'b0;
    end else begin
      s1          <= toneIn;
      s2          <= s1;
      s3          <= s2;
      periodValid <= 1'b0;

      case (state)
        IDLE: begin
          // First edge only establishes the reference; nothing to report.
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
            hcnt  <= PERIOD_W'(1);
          end
        end

        MEASURE: begin
          // A rise on the timeout cycle still wins and is measured.
          if (rise) begin
            period      <= newPeriod;
            highTime    <= hcnt;
            periodValid <= 1'b1;
            stableCnt   <= nextStable;
            toneActive  <= (nextStable == SC_MAX);
            cnt         <= '0;
            hcnt        <= PERIOD_W'(1);
          end else if (cnt == CNT_LAST) begin
            state      <= IDLE;
            period     <= '0;
            highTime   <= '0;
            stableCnt  <= '0;
            toneActive <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
          end else begin
            cnt  <= cnt + 1'b1;
            hcnt <= hcnt + PERIOD_W'(s2);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
Receive-side counterpart of the buzzer square-wave drive. Samples an asynchronous tone input, such as a clockDivider output looped back or an external buzzer/mic comparator, on the system clock. Measures period and high time in clk cycles and flags when a steady tone is present. Used for self-test of the buzzer path and as a simple tone detector.

Parameters:
PERIOD_W, 24, width of the period and high-time counters and outputs.
TIMEOUT, 1000000, number of clk cycles without a rising edge before the tone is declared absent; must be at most 2^PERIOD_W-1 and at least 2.
STABLE_N, 4, number of consecutive in-tolerance periods required to assert toneActive; must be at least 1.
TOL, 2, maximum absolute difference in clk cycles between consecutive periods that still counts as stable.

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
toneIn  input  1  asynchronous square-wave input.
period  output  PERIOD_W  last measured period in clk cycles (rising edge to rising edge).
highTime  output  PERIOD_W  clk cycles the synchronized input was high during the last measured period.
periodValid  output  1  one-cycle pulse; period and highTime were updated this cycle.
toneActive  output  1  steady tone present.

Behaviour:
- Reset (reset=0, async): sync flops=0, state=IDLE, cnt=0, hcnt=0, stableCnt=0, period=0, highTime=0, periodValid=0, toneActive=0. Reset mid-measurement discards the partial period; no pulse follows release.
- Input path: 2-flop synchronizer (s1, s2), then edge register s3. rise = s2 & ~s3. Fixed 3-cycle latency from toneIn to rise. All edges see the same latency, so measurements are unaffected. No glitch filter; every synchronized rising edge counts.
- States: IDLE (no reference edge yet) and MEASURE.
- IDLE: on rise, go to MEASURE with cnt<=0 and hcnt<=1. No periodValid is produced.
- MEASURE, each cycle without rise: cnt<=cnt+1; hcnt<=hcnt+s2.
- MEASURE on rise:
  - period<=cnt+1; highTime<=hcnt; periodValid<=1 for exactly one cycle, coincident with the new values.
  - Then restart: cnt<=0, hcnt<=1.
  - An input with period P cycles and high time H reports period=P, highTime=H.
- Timeout: in MEASURE, if cnt==TIMEOUT-1 and no rise this cycle, go to IDLE. Set period<=0, highTime<=0, stableCnt<=0, toneActive<=0. No periodValid.
- Simultaneous rise and timeout cycle: rise wins; measurement taken normally.
- Counters never exceed TIMEOUT, so cnt+1 never overflows PERIOD_W.
- Stability, evaluated on each valid period:
  - First valid period after IDLE or reset: stableCnt<=1.
  - Later periods: if |new period - previous period| <= TOL, stableCnt<=min(stableCnt+1, STABLE_N); otherwise stableCnt<=1.
  - Difference computed unsigned on PERIOD_W+1 bits.
- toneActive is registered and equals (stableCnt==STABLE_N). It updates in the same cycle as periodValid, or at timeout.
- Input held constantly high or constantly low in MEASURE: no rise occurs, so timeout applies.

Test Plan:
Setup: TIMEOUT=5000, STABLE_N=4, TOL=2, toneIn driven synchronously to clk.
1. Hold reset=0 while toggling toneIn every 10 cycles -> all outputs stay 0. Release reset -> first periodValid only at the 2nd detected rise.
2. Square wave with period 1000, high 500 -> each periodValid shows period=1000, highTime=500. toneActive=1 on the 4th periodValid (5th rise) and stays 1.
3. Duty 300 high / 700 low -> period=1000, highTime=300. Then 1-cycle-high pulses every 1000 cycles -> highTime=1.
4. Periods 1000,1001,1003,1002 -> toneActive=1 on the 4th pulse. Next period 1006 (diff 4) -> stableCnt=1, toneActive=0 in that pulse cycle. Three more periods of 1006 -> toneActive=1 again.
5. Active tone, then hold toneIn high -> exactly 5000 cycles after the last detected rise: toneActive=0, period=0, highTime=0, no pulse. The next rise produces no periodValid; the following rise does.
6. Assert reset for 3 cycles midway through a period while toneActive=1 -> outputs 0 immediately (async). After release, the 1000-cycle tone needs 5 rises to reassert toneActive.
